vga_timing_gen: RTL and testbench

Raster timing generator for the EyeTracker display path. It runs off the pixel clock VCLK and produces registered HSYNC, VSYNC and DE together with the raster coordinates that the VGA output stage uses to index its line memories and draw the point/edge markers. It also issues a per-line prefetch request with a handshake, so the line-memory loader can fill the next active line during horizontal blanking. Frame start and frame count outputs are provided for the tracker control logic.

---
 rtl/vga_timing_gen.sv | 174 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the EyeTracker VGA path.
// Produces registered HSYNC/VSYNC/DE and raster coordinates, a per-line
// prefetch request for the line-memory loader, frame start/count outputs,
// and a sticky underrun flag for requests the loader never accepted.
module vga_timing_gen #(
    parameter int ADDR_WIDTH = 11,
    parameter int HACTIVE    = 640,
    parameter int HFP        = 16,
    parameter int HSYNC_W    = 96,
    parameter int HBP        = 48,
    parameter int VACTIVE    = 480,
    parameter int VFP        = 10,
    parameter int VSYNC_W    = 2,
    parameter int VBP        = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0
) (
    input  logic                  VCLK,
    input  logic                  RST_N,
    input  logic                  iEN,
    input  logic                  iLINE_ACK,
    output logic                  oHSYNC,
    output logic                  oVSYNC,
    output logic                  oDE,
    output logic [ADDR_WIDTH-1:0] oH_ADDR,
    output logic [ADDR_WIDTH-1:0] oV_ADDR,
    output logic                  oFRAME_START,
    output logic [15:0]           oFRAME_CNT,
    output logic                  oLINE_REQ,
    output logic [ADDR_WIDTH-1:0] oLINE_NUM,
    output logic                  oUNDERRUN
);

    localparam int HTOTAL = HACTIVE + HFP + HSYNC_W + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYNC_W + VBP;

    localparam logic [ADDR_WIDTH-1:0] L_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] L_HMAX = ADDR_WIDTH'(HTOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] L_VMAX = ADDR_WIDTH'(VTOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] L_HACT = ADDR_WIDTH'(HACTIVE);
    localparam logic [ADDR_WIDTH-1:0] L_VACT = ADDR_WIDTH'(VACTIVE);
    localparam logic [ADDR_WIDTH-1:0] L_HSS  = ADDR_WIDTH'(HACTIVE + HFP);
    localparam logic [ADDR_WIDTH-1:0] L_HSE  = ADDR_WIDTH'(HACTIVE + HFP + HSYNC_W);
    localparam logic [ADDR_WIDTH-1:0] L_VSS  = ADDR_WIDTH'(VACTIVE + VFP);
    localparam logic [ADDR_WIDTH-1:0] L_VSE  = ADDR_WIDTH'(VACTIVE + VFP + VSYNC_W);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_h;
    logic [ADDR_WIDTH-1:0]   r_v;
    logic                    r_hsync;
    logic                    r_vsync;
    logic                    r_de;
    logic                    r_frameStart;
    logic [15:0]             r_frameCnt;
    logic                    r_lineReq;
    logic [ADDR_WIDTH-1:0]   r_lineNum;
    logic                    r_underrun;

    state_t                  w_stateNext;
    logic [ADDR_WIDTH-1:0]   w_h;
    logic [ADDR_WIDTH-1:0]   w_v;
    logic [ADDR_WIDTH-1:0]   w_nextLine;
    logic                    w_hWrap;
    logic                    w_hsync;
    logic                    w_vsync;
    logic                    w_de;
    logic                    w_frameStart;
    logic [15:0]             w_frameCnt;
    logic                    w_lineReq;
    logic [ADDR_WIDTH-1:0]   w_lineNum;
    logic                    w_underrun;

    // Next position, decoded outputs and request bookkeeping; outputs are
    // decoded from the next position so they register coherent with it.
    always_comb begin
        w_stateNext  = S_IDLE;
        w_h          = '0;
        w_v          = '0;
        w_nextLine   = '0;
        w_hWrap      = 1'b0;
        w_hsync      = ~HSYNC_POL;
        w_vsync      = ~VSYNC_POL;
        w_de         = 1'b0;
        w_frameStart = 1'b0;
        w_frameCnt   = '0;
        w_lineReq    = 1'b0;
        w_lineNum    = '0;
        w_underrun   = 1'b0;

        if (iEN) begin
            w_stateNext = S_RUN;
            w_frameCnt  = r_frameCnt;
            w_lineReq   = r_lineReq;
            w_lineNum   = r_lineNum;
            w_underrun  = r_underrun;

            if (r_state == S_RUN) begin
                w_hWrap = (r_h == L_HMAX);
                w_h     = w_hWrap ? '0 : r_h + L_ONE;
                w_v     = r_v;
                if (w_hWrap) begin
                    w_v = (r_v == L_VMAX) ? '0 : r_v + L_ONE;
                    if (r_v == L_VMAX) begin
                        w_frameCnt = r_frameCnt + 16'd1;
                    end
                end
            end

            w_de         = (w_h < L_HACT) && (w_v < L_VACT);
            w_hsync      = ((w_h >= L_HSS) && (w_h < L_HSE)) ? HSYNC_POL : ~HSYNC_POL;
            w_vsync      = ((w_v >= L_VSS) && (w_v < L_VSE)) ? VSYNC_POL : ~VSYNC_POL;
            w_frameStart = (w_h == '0) && (w_v == '0);
            w_nextLine   = (w_v == L_VMAX) ? '0 : w_v + L_ONE;

            if (r_lineReq && iLINE_ACK) begin
                w_lineReq = 1'b0;
            end else if (r_lineReq && (w_h == '0) && (w_v == r_lineNum)) begin
                w_lineReq  = 1'b0;
                w_underrun = 1'b1;
            end

            if ((w_h == L_HACT) && (w_nextLine < L_VACT)) begin
                w_lineReq = 1'b1;
                w_lineNum = w_nextLine;
            end
        end
    end

    // State and output registers; async reset, idle values match reset values.
    always_ff @(posedge VCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_h          <= '0;
            r_v          <= '0;
            r_hsync      <= ~HSYNC_POL;
            r_vsync      <= ~VSYNC_POL;
            r_de         <= 1'b0;
            r_frameStart <= 1'b0;
            r_frameCnt   <= '0;
            r_lineReq    <= 1'b0;
            r_lineNum    <= '0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_h          <= w_h;
            r_v          <= w_v;
            r_hsync      <= w_hsync;
            r_vsync      <= w_vsync;
            r_de         <= w_de;
            r_frameStart <= w_frameStart;
            r_frameCnt   <= w_frameCnt;
            r_lineReq    <= w_lineReq;
            r_lineNum    <= w_lineNum;
            r_underrun   <= w_underrun;
        end
    end

    assign oHSYNC       = r_hsync;
    assign oVSYNC       = r_vsync;
    assign oDE          = r_de;
    assign oH_ADDR      = r_h;
    assign oV_ADDR      = r_v;
    assign oFRAME_START = r_frameStart;
    assign oFRAME_CNT   = r_frameCnt;
    assign oLINE_REQ    = r_lineReq;
    assign oLINE_NUM    = r_lineNum;
    assign oUNDERRUN    = r_underrun;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced raster
// (25 x 15 total, 16 x 8 active) so several whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int AW      = 11;
    localparam int HACT    = 16;
    localparam int HFPW    = 2;
    localparam int HSW     = 4;
    localparam int HBPW    = 3;
    localparam int VACT    = 8;
    localparam int VFPW    = 2;
    localparam int VSW     = 2;
    localparam int VBPW    = 3;
    localparam int HTOT    = 25;
    localparam int VTOT    = 15;
    localparam int FRAME   = 375;

    logic          VCLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          iEN = 1'b0;
    logic          iLINE_ACK = 1'b0;
    logic          oHSYNC;
    logic          oVSYNC;
    logic          oDE;
    logic [AW-1:0] oH_ADDR;
    logic [AW-1:0] oV_ADDR;
    logic          oFRAME_START;
    logic [15:0]   oFRAME_CNT;
    logic          oLINE_REQ;
    logic [AW-1:0] oLINE_NUM;
    logic          oUNDERRUN;

    typedef enum int {SIG_H, SIG_V, SIG_DE, SIG_HS, SIG_VS, SIG_FS, SIG_REQ, SIG_NUM, SIG_UND, SIG_FCNT} sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        int          at;
        logic [15:0] val;
    } exp_t;

    exp_t expQ[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   ackDelay = 5;
    int   reqAge = 0;
    int   e1;
    int   e2;
    int   base;

    vga_timing_gen #(
        .ADDR_WIDTH(AW), .HACTIVE(HACT), .HFP(HFPW), .HSYNC_W(HSW), .HBP(HBPW),
        .VACTIVE(VACT), .VFP(VFPW), .VSYNC_W(VSW), .VBP(VBPW),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .VCLK(VCLK),
        .RST_N(RST_N),
        .iEN(iEN),
        .iLINE_ACK(iLINE_ACK),
        .oHSYNC(oHSYNC),
        .oVSYNC(oVSYNC),
        .oDE(oDE),
        .oH_ADDR(oH_ADDR),
        .oV_ADDR(oV_ADDR),
        .oFRAME_START(oFRAME_START),
        .oFRAME_CNT(oFRAME_CNT),
        .oLINE_REQ(oLINE_REQ),
        .oLINE_NUM(oLINE_NUM),
        .oUNDERRUN(oUNDERRUN)
    );

    // Pixel clock.
    always #5 VCLK = ~VCLK;

    // Free-running cycle index used to time-stamp every expectation.
    always @(posedge VCLK) cyc <= cyc + 1;

    // Loader model: acks a pending request ackDelay cycles after it rises;
    // a negative delay means the loader never acks.
    always @(negedge VCLK) begin
        if (!RST_N || ackDelay < 0) begin
            iLINE_ACK = 1'b0;
            reqAge = 0;
        end else if (oLINE_REQ) begin
            iLINE_ACK = (reqAge == ackDelay);
            reqAge++;
        end else begin
            iLINE_ACK = 1'b0;
            reqAge = 0;
        end
    end

    function automatic int pos(int v, int h);
        return v * HTOT + h;
    endfunction

    function automatic logic [15:0] sample(sig_e s);
        case (s)
            SIG_H:    return 16'(oH_ADDR);
            SIG_V:    return 16'(oV_ADDR);
            SIG_DE:   return 16'(oDE);
            SIG_HS:   return 16'(oHSYNC);
            SIG_VS:   return 16'(oVSYNC);
            SIG_FS:   return 16'(oFRAME_START);
            SIG_REQ:  return 16'(oLINE_REQ);
            SIG_NUM:  return 16'(oLINE_NUM);
            SIG_UND:  return 16'(oUNDERRUN);
            SIG_FCNT: return oFRAME_CNT;
            default:  return 16'hFFFF;
        endcase
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [15:0] got;
        checks++;
        if (e.at != cyc) begin
            $display("[TB] FAIL %s: not sampled at cycle %0d (now %0d)", e.name, e.at, cyc);
        end else begin
            got = sample(e.sig);
            if (got === e.val) begin
                passes++;
            end else begin
                $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, got, e.val, cyc);
            end
        end
    endtask

    // Monitor: compares every due expectation against the DUT on the falling edge.
    always @(negedge VCLK) begin
        for (int i = expQ.size() - 1; i >= 0; i--) begin
            if (expQ[i].at <= cyc) begin
                checkOutput(expQ[i]);
                expQ.delete(i);
            end
        end
    end

    task automatic expectAt(input string nm, input sig_e s, input int at, input int val);
        exp_t e;
        e.name = nm;
        e.sig  = s;
        e.at   = at;
        e.val  = 16'(val);
        expQ.push_back(e);
    endtask

    task automatic expectIdle(input string nm, input int at);
        expectAt({nm, "_h"},   SIG_H,    at, 0);
        expectAt({nm, "_v"},   SIG_V,    at, 0);
        expectAt({nm, "_de"},  SIG_DE,   at, 0);
        expectAt({nm, "_hs"},  SIG_HS,   at, 1);
        expectAt({nm, "_vs"},  SIG_VS,   at, 1);
        expectAt({nm, "_fs"},  SIG_FS,   at, 0);
        expectAt({nm, "_req"}, SIG_REQ,  at, 0);
        expectAt({nm, "_num"}, SIG_NUM,  at, 0);
        expectAt({nm, "_und"}, SIG_UND,  at, 0);
        expectAt({nm, "_fc"},  SIG_FCNT, at, 0);
    endtask

    task automatic applyStimulus(input logic rstN, input logic en);
        RST_N = rstN;
        iEN   = en;
    endtask

    task automatic waitCyc(input int target);
        while (cyc < target) @(negedge VCLK);
    endtask

    // Directed stimulus; each phase queues its hand-computed expectations first.
    initial begin
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge VCLK);
        base = cyc;
        expectIdle("rst", base + 1);
        applyStimulus(1'b0, 1'b1);
        expectIdle("rstEn", base + 2);
        waitCyc(base + 3);
        applyStimulus(1'b1, 1'b1);
        e1 = cyc + 1;

        // Start-up and horizontal timing of line 0.
        expectAt("start_h",  SIG_H,   e1, 0);
        expectAt("start_v",  SIG_V,   e1, 0);
        expectAt("start_de", SIG_DE,  e1, 1);
        expectAt("start_fs", SIG_FS,  e1, 1);
        expectAt("start_hs", SIG_HS,  e1, 1);
        expectAt("start_vs", SIG_VS,  e1, 1);
        expectAt("start_fc", SIG_FCNT, e1, 0);
        expectAt("deLast",   SIG_DE,  e1 + 15, 1);
        expectAt("deOff",    SIG_DE,  e1 + 16, 0);
        expectAt("reqRise",  SIG_REQ, e1 + 16, 1);
        expectAt("reqNum1",  SIG_NUM, e1 + 16, 1);
        expectAt("hsPre",    SIG_HS,  e1 + 17, 1);
        expectAt("hsOn",     SIG_HS,  e1 + 18, 0);
        expectAt("hsEnd",    SIG_HS,  e1 + 21, 0);
        expectAt("hsOff",    SIG_HS,  e1 + 22, 1);
        expectAt("reqHeld",  SIG_REQ, e1 + 21, 1);
        expectAt("reqClr",   SIG_REQ, e1 + 22, 0);
        expectAt("hMax",     SIG_H,   e1 + 24, 24);
        expectAt("hWrap",    SIG_H,   e1 + 25, 0);
        expectAt("vInc",     SIG_V,   e1 + 25, 1);
        expectAt("noUnd1",   SIG_UND, e1 + 25, 0);
        expectAt("fsNo",     SIG_FS,  e1 + 25, 0);

        // Requests, vertical timing and frame count.
        expectAt("req3",     SIG_REQ, e1 + pos(2, 16), 1);
        expectAt("num3",     SIG_NUM, e1 + pos(2, 16), 3);
        expectAt("deL7",     SIG_DE,  e1 + pos(7, 0), 1);
        expectAt("deL8",     SIG_DE,  e1 + pos(8, 0), 0);
        expectAt("noReq7",   SIG_REQ, e1 + pos(7, 16), 0);
        expectAt("noReq13",  SIG_REQ, e1 + pos(13, 16), 0);
        expectAt("req14",    SIG_REQ, e1 + pos(14, 16), 1);
        expectAt("num0",     SIG_NUM, e1 + pos(14, 16), 0);
        expectAt("vsPre",    SIG_VS,  e1 + pos(9, 24), 1);
        expectAt("vsOn",     SIG_VS,  e1 + pos(10, 0), 0);
        expectAt("vsEnd",    SIG_VS,  e1 + pos(11, 24), 0);
        expectAt("vsOff",    SIG_VS,  e1 + pos(12, 0), 1);
        expectAt("hEnd",     SIG_H,   e1 + pos(14, 24), 24);
        expectAt("vEnd",     SIG_V,   e1 + pos(14, 24), 14);
        expectAt("fsLast",   SIG_FS,  e1 + pos(14, 24), 0);
        expectAt("fcPre",    SIG_FCNT, e1 + pos(14, 24), 0);
        expectAt("fs1",      SIG_FS,  e1 + FRAME, 1);
        expectAt("fc1",      SIG_FCNT, e1 + FRAME, 1);
        expectAt("fsAfter",  SIG_FS,  e1 + FRAME + 1, 0);
        expectAt("fs2",      SIG_FS,  e1 + 2 * FRAME, 1);
        expectAt("fc2",      SIG_FCNT, e1 + 2 * FRAME, 2);
        expectAt("fs3",      SIG_FS,  e1 + 3 * FRAME, 1);
        expectAt("fc3",      SIG_FCNT, e1 + 3 * FRAME, 3);
        expectAt("noUnd3",   SIG_UND, e1 + 3 * FRAME, 0);

        // Mid-frame abort while the request for line 6 is pending.
        expectAt("abH",      SIG_H,   e1 + 3 * FRAME + pos(5, 18), 18);
        expectAt("abReq",    SIG_REQ, e1 + 3 * FRAME + pos(5, 18), 1);
        expectAt("abNum",    SIG_NUM, e1 + 3 * FRAME + pos(5, 18), 6);
        expectAt("abFc",     SIG_FCNT, e1 + 3 * FRAME + pos(5, 18), 3);
        expectIdle("abort",  e1 + 3 * FRAME + pos(5, 19));
        expectIdle("idle",   e1 + 3 * FRAME + pos(5, 21));
        waitCyc(e1 + 3 * FRAME + pos(5, 18));
        applyStimulus(1'b1, 1'b0);

        // Restart with a loader that never acks.
        waitCyc(e1 + 3 * FRAME + pos(5, 22));
        ackDelay = -1;
        applyStimulus(1'b1, 1'b1);
        e2 = cyc + 1;
        expectAt("re_h",     SIG_H,   e2, 0);
        expectAt("re_v",     SIG_V,   e2, 0);
        expectAt("re_fs",    SIG_FS,  e2, 1);
        expectAt("re_de",    SIG_DE,  e2, 1);
        expectAt("re_fc",    SIG_FCNT, e2, 0);
        expectAt("re_h1",    SIG_H,   e2 + 1, 1);
        expectAt("uReq",     SIG_REQ, e2 + 24, 1);
        expectAt("uUnd0",    SIG_UND, e2 + 24, 0);
        expectAt("uExp",     SIG_REQ, e2 + 25, 0);
        expectAt("uSet",     SIG_UND, e2 + 25, 1);
        expectAt("uReq2",    SIG_REQ, e2 + 46, 1);
        expectAt("uAck2",    SIG_REQ, e2 + 47, 0);
        expectAt("uHold50",  SIG_UND, e2 + 50, 1);
        expectAt("uHold100", SIG_UND, e2 + 100, 1);
        expectIdle("stop",   e2 + 101);
        waitCyc(e2 + 30);
        ackDelay = 5;
        waitCyc(e2 + 100);
        applyStimulus(1'b1, 1'b0);
        waitCyc(e2 + 105);

        foreach (expQ[i]) begin
            checks++;
            $display("[TB] FAIL %s: never compared (due cycle %0d)", expQ[i].name, expQ[i].at);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
